med_dispense_ctrl: RTL and testbench

- Downstream consumer of the dose-schedule stage.
- Takes the four per-compartment "dose due" lines (med_0..med_3, bundled as med_due) and turns each new due event into one dispense:
  - drives the compartment motor with a done/timeout handshake;
  - sounds the buzzer until the patient acknowledges;
  - tracks pill stock per compartment and counts missed doses.

---
 rtl/med_pkg.sv | 18 +
 rtl/med_pending_arb.sv | 40 ++++
 rtl/med_dispense_ctrl.sv | 140 ++++++++++++++
 tb/tb_med_dispense_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/med_pkg.sv
// Shared types and defaults for the medication dispenser datapath.
package med_pkg;

    localparam int NUM_MED           = 4;
    localparam int SEL_W             = 2;
    localparam int DEF_STOCK_W       = 5;
    localparam int DEF_MOTOR_TIMEOUT = 15;
    localparam int DEF_ACK_TIMEOUT   = 63;
    localparam int DEF_MISS_W        = 4;

    typedef enum logic [1:0] {
        IDLE,
        MOTOR,
        ALERT,
        FAULT
    } state_t;

endpackage

// File: rtl/med_pending_arb.sv
// Dose-due edge detect, sticky pending bits and lowest-index grant.
module med_pending_arb
    import med_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_MED-1:0] med_due,
    input  logic               grant_clr,
    output logic               any_pending,
    output logic [SEL_W-1:0]   grant
);

    logic [NUM_MED-1:0] due_prev;
    logic [NUM_MED-1:0] pending;
    logic [NUM_MED-1:0] clr_mask;
    logic [NUM_MED-1:0] rise;

    assign rise        = med_due & ~due_prev;
    assign any_pending = |pending;
    assign clr_mask    = grant_clr ? (NUM_MED'(1) << grant) : '0;

    always_comb begin
        grant = '0;
        for (int i = NUM_MED - 1; i >= 0; i--) begin
            if (pending[i]) grant = SEL_W'(i);
        end
    end

    // A fresh rising edge wins over the grant clear of the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            due_prev <= '0;
            pending  <= '0;
        end else begin
            due_prev <= med_due;
            pending  <= (pending & ~clr_mask) | rise;
        end
    end

endmodule

// File: rtl/med_dispense_ctrl.sv
// Dispense sequencer: motor handshake, patient alert, stock and miss tracking.
module med_dispense_ctrl
    import med_pkg::*;
#(
    parameter int STOCK_W       = DEF_STOCK_W,
    parameter int MOTOR_TIMEOUT = DEF_MOTOR_TIMEOUT,
    parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT,
    parameter int MISS_W        = DEF_MISS_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_MED-1:0] med_due,
    input  logic               refill_ld,
    input  logic [SEL_W-1:0]   refill_sel,
    input  logic [STOCK_W-1:0] refill_qty,
    input  logic               motor_done,
    input  logic               patient_ack,
    output logic               motor_en,
    output logic [SEL_W-1:0]   motor_sel,
    output logic               buzzer,
    output logic               dispensed_pulse,
    output logic [NUM_MED-1:0] empty_flags,
    output logic               fault,
    output logic [MISS_W-1:0]  missed_cnt,
    output logic               busy
);

    localparam int TMAX    = (ACK_TIMEOUT > MOTOR_TIMEOUT) ? ACK_TIMEOUT : MOTOR_TIMEOUT;
    localparam int TIMER_W = $clog2(TMAX + 1);

    state_t             state;
    state_t             next_state;
    logic [TIMER_W-1:0] timer;
    logic [STOCK_W-1:0] stock [NUM_MED];
    logic               any_pending;
    logic [SEL_W-1:0]   grant;
    logic               grant_clr;
    logic               timer_clr;
    logic               set_empty;
    logic               dec;
    logic               fault_set;
    logic               miss_inc;

    med_pending_arb u_arb (
        .clk         (clk),
        .reset       (reset),
        .med_due     (med_due),
        .grant_clr   (grant_clr),
        .any_pending (any_pending),
        .grant       (grant)
    );

    always_comb begin
        next_state = state;
        grant_clr  = 1'b0;
        timer_clr  = 1'b0;
        set_empty  = 1'b0;
        dec        = 1'b0;
        fault_set  = 1'b0;
        miss_inc   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_pending) begin
                    grant_clr = 1'b1;
                    if (stock[grant] == '0) begin
                        set_empty = 1'b1;
                    end else begin
                        next_state = MOTOR;
                        timer_clr  = 1'b1;
                    end
                end
            end
            MOTOR: begin
                if (motor_done) begin
                    dec        = 1'b1;
                    timer_clr  = 1'b1;
                    next_state = ALERT;
                end else if (timer == TIMER_W'(MOTOR_TIMEOUT)) begin
                    fault_set  = 1'b1;
                    next_state = FAULT;
                end
            end
            ALERT: begin
                if (patient_ack) begin
                    next_state = IDLE;
                end else if (timer == TIMER_W'(ACK_TIMEOUT)) begin
                    miss_inc   = 1'b1;
                    next_state = IDLE;
                end
            end
            FAULT: ;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            timer           <= '0;
            motor_sel       <= '0;
            dispensed_pulse <= 1'b0;
            fault           <= 1'b0;
            missed_cnt      <= '0;
        end else begin
            state           <= next_state;
            dispensed_pulse <= dec;
            fault           <= fault | fault_set;
            if (timer_clr) begin
                timer <= '0;
            end else if (state == MOTOR || state == ALERT) begin
                timer <= timer + 1'b1;
            end
            if (timer_clr && state == IDLE) motor_sel <= grant;
            if (miss_inc && missed_cnt != '1) missed_cnt <= missed_cnt + 1'b1;
        end
    end

    // Refill takes priority over both decrement and the empty flag set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_MED; i++) stock[i] <= '0;
            empty_flags <= '0;
        end else begin
            for (int i = 0; i < NUM_MED; i++) begin
                if (refill_ld && refill_sel == SEL_W'(i)) begin
                    stock[i]       <= refill_qty;
                    empty_flags[i] <= 1'b0;
                end else begin
                    if (dec && motor_sel == SEL_W'(i)) stock[i] <= stock[i] - 1'b1;
                    if (set_empty && grant == SEL_W'(i)) empty_flags[i] <= 1'b1;
                end
            end
        end
    end

    assign motor_en = (state == MOTOR);
    assign buzzer   = (state == ALERT) || (state == FAULT);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_med_dispense_ctrl.sv
// Directed and random checks of med_dispense_ctrl against a dose-level model.
module tb_med_dispense_ctrl;
    import med_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] med_due;
    logic       refill_ld;
    logic [1:0] refill_sel;
    logic [4:0] refill_qty;
    logic       motor_done;
    logic       patient_ack;
    logic       motor_en;
    logic [1:0] motor_sel;
    logic       buzzer;
    logic       dispensed_pulse;
    logic [3:0] empty_flags;
    logic       fault;
    logic [3:0] missed_cnt;
    logic       busy;

    int errors = 0;
    int checks = 0;

    bit [3:0] m_prev, m_pend, m_empty;
    int       m_stock [4];
    bit       m_fault, m_pulse, m_motor, m_alert;
    int       m_sel, m_elapsed, m_missed;
    int       pulses, buzz;

    always #5 clk = ~clk;

    med_dispense_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .med_due         (med_due),
        .refill_ld       (refill_ld),
        .refill_sel      (refill_sel),
        .refill_qty      (refill_qty),
        .motor_done      (motor_done),
        .patient_ack     (patient_ack),
        .motor_en        (motor_en),
        .motor_sel       (motor_sel),
        .buzzer          (buzzer),
        .dispensed_pulse (dispensed_pulse),
        .empty_flags     (empty_flags),
        .fault           (fault),
        .missed_cnt      (missed_cnt),
        .busy            (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_prev = '0; m_pend = '0; m_empty = '0;
        for (int i = 0; i < 4; i++) m_stock[i] = 0;
        m_fault = 0; m_pulse = 0; m_motor = 0; m_alert = 0;
        m_sel = 0; m_elapsed = 0; m_missed = 0;
    endfunction

    function automatic void model_step();
        bit [3:0] ev;
        ev = med_due & ~m_prev;
        m_pulse = 0;
        if (!m_motor && !m_alert && !m_fault) begin
            if (m_pend != 0) begin
                int g = 0;
                while (!m_pend[g]) g++;
                m_pend[g] = 0;
                if (m_stock[g] == 0) m_empty[g] = 1;
                else begin m_motor = 1; m_sel = g; m_elapsed = 0; end
            end
        end else if (m_motor) begin
            if (motor_done) begin
                m_stock[m_sel]--;
                m_pulse = 1; m_motor = 0; m_alert = 1; m_elapsed = 0;
            end else if (m_elapsed == DEF_MOTOR_TIMEOUT) begin
                m_fault = 1; m_motor = 0;
            end else m_elapsed++;
        end else if (m_alert) begin
            if (patient_ack) m_alert = 0;
            else if (m_elapsed == DEF_ACK_TIMEOUT) begin
                m_alert = 0;
                if (m_missed < 15) m_missed++;
            end else m_elapsed++;
        end
        m_pend |= ev;
        m_prev = med_due;
        if (refill_ld) begin
            m_stock[refill_sel] = int'(refill_qty);
            m_empty[refill_sel] = 0;
        end
    endfunction

    task automatic check_all();
        chk("motor_en", 32'(motor_en), 32'(m_motor));
        if (m_motor) chk("motor_sel", 32'(motor_sel), 32'(m_sel));
        chk("buzzer", 32'(buzzer), 32'(m_alert || m_fault));
        chk("pulse", 32'(dispensed_pulse), 32'(m_pulse));
        chk("empty", 32'(empty_flags), 32'(m_empty));
        chk("fault", 32'(fault), 32'(m_fault));
        chk("missed", 32'(missed_cnt), 32'(m_missed));
        chk("busy", 32'(busy), 32'(m_motor || m_alert || m_fault));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        refill_ld   = 0;
        motor_done  = 0;
        patient_ack = 0;
    endtask

    task automatic do_reset();
        reset = 0;
        model_reset();
        #1 check_all();
        @(negedge clk);
        reset = 1;
    endtask

    task automatic refill(input int sel, input int qty);
        refill_ld  = 1;
        refill_sel = 2'(sel);
        refill_qty = 5'(qty);
        tick();
    endtask

    // Responds to the motor after ddly cycles and to the alert after adly; -1 never.
    task automatic run_auto(input int n, input int ddly, input int adly,
                            input bit rf = 0, input int rsel = 0, input int rqty = 0);
        pulses = 0;
        buzz   = 0;
        for (int i = 0; i < n; i++) begin
            motor_done  = m_motor && ddly >= 0 && m_elapsed == ddly;
            patient_ack = m_alert && adly >= 0 && m_elapsed == adly;
            if (rf && motor_done) begin
                refill_ld  = 1;
                refill_sel = 2'(rsel);
                refill_qty = 5'(rqty);
            end
            tick();
            if (dispensed_pulse) pulses++;
            if (buzzer) buzz++;
        end
    endtask

    initial begin
        bit stuck;
        int fault_age;
        med_due = 0; refill_ld = 0; refill_sel = 0; refill_qty = 0;
        motor_done = 0; patient_ack = 0; reset = 0;
        model_reset();
        @(negedge clk);
        check_all();
        reset = 1;

        refill(2, 3);
        med_due = 4'b0100; tick();
        med_due = 0; tick();
        chk("t1_en", 32'(motor_en), 1);
        chk("t1_sel", 32'(motor_sel), 2);
        run_auto(20, 4, 2);
        chk("t1_pulses", pulses, 1);
        chk("t1_stock2", 32'(dut.stock[2]), 2);
        chk("t1_buzz", 32'(buzzer), 0);

        refill(0, 1);
        refill(3, 1);
        med_due = 4'b1001; tick();
        med_due = 0;
        run_auto(40, 2, 1);
        chk("t2_pulses", pulses, 2);
        chk("t2_stock0", 32'(dut.stock[0]), 0);
        chk("t2_stock3", 32'(dut.stock[3]), 0);

        med_due = 4'b0010; tick();
        med_due = 0;
        run_auto(4, 0, 0);
        chk("t3_empty", 32'(empty_flags[1]), 1);
        chk("t3_pulses", pulses, 0);
        refill(1, 2);
        chk("t3_clr", 32'(empty_flags[1]), 0);

        refill(0, 5);
        med_due = 4'b0001; tick();
        med_due = 0;
        run_auto(20, -1, -1);
        chk("t4_fault", 32'(fault), 1);
        chk("t4_en", 32'(motor_en), 0);
        med_due = 4'b0001; tick();
        run_auto(5, -1, -1);
        chk("t4_pend", 32'(dut.u_arb.pending[0]), 1);
        med_due = 0;
        do_reset();
        chk("t4_rst_fault", 32'(fault), 0);

        refill(3, 31);
        for (int k = 0; k < 17; k++) begin
            med_due = 4'b1000; tick();
            med_due = 0;
            run_auto(70, 0, -1);
            chk("t5_alert_len", buzz, 64);
        end
        chk("t5_missed", 32'(missed_cnt), 15);

        refill(1, 5);
        med_due = 4'b0010;
        run_auto(80, 1, 0);
        chk("t6_hold", pulses, 1);
        med_due = 0; tick();
        med_due = 4'b0010; tick();
        run_auto(20, 1, 0, 1, 1, 9);
        chk("t6_pulses", pulses, 1);
        chk("t6_stock1", 32'(dut.stock[1]), 9);
        med_due = 0; tick();

        stuck = 0;
        fault_age = 0;
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 29) == 0) med_due[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 24) == 0) begin
                refill_ld  = 1;
                refill_sel = 2'($urandom_range(0, 3));
                refill_qty = 5'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 399) == 0) stuck = ~stuck;
            motor_done  = m_motor && !stuck && $urandom_range(0, 2) == 0;
            patient_ack = m_alert && $urandom_range(0, 15) == 0;
            tick();
            if (m_fault) fault_age++;
            if (fault_age > 30) begin
                fault_age = 0;
                stuck = 0;
                do_reset();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
